// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants, FSM encoding and prefetch entry type for the fetch stage.
package fetch_pkg;
    localparam logic [31:0] NOP = 32'h0;
    localparam int DEFAULT_DEPTH = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [0:0] FETCH = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetchEntry_t;
    function automatic logic [31:0] wordAlign(input logic [31:0] addr);
        return addr & ~32'h3;
    endfunction
endpackage

// File: rtl/instr_fetch_stage_if.sv
// instr_fetch_stage_if: request/grant plus in-order response bus between fetch and instruction memory.
interface instr_fetch_stage_if;
    logic        MemReq;
    logic [31:0] MemAddr;
    logic        MemGnt;
    logic        MemRespValid;
    logic [31:0] MemRespData;
    modport master (output MemReq, MemAddr, input MemGnt, MemRespValid, MemRespData);
    modport slave (input MemReq, MemAddr, output MemGnt, MemRespValid, MemRespData);
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous prefetch FIFO of {pc, instr} entries; flush empties it in one cycle.
module fetch_fifo import fetch_pkg::*; #(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    push,
    input  logic                    pop,
    input  logic                    flush,
    input  fetchEntry_t             entry,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count,
    output fetchEntry_t             head
);
    localparam int AW = $clog2(DEPTH);
    fetchEntry_t slots [DEPTH];
    logic [AW-1:0] wrPtr, rdPtr;
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign head = slots[rdPtr];
    always_ff @(posedge Clk) begin
        if (push) slots[wrPtr] <= entry;
    end
    always_ff @(posedge Clk) begin
        if (Reset || flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + AW'(1);
            if (pop) rdPtr <= rdPtr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
endmodule

// File: rtl/instr_fetch_stage.sv
// instr_fetch_stage: PC owner feeding decode from a prefetch FIFO, with redirect and wrong-path drop.
// Defining FETCH_PERF_CNT_EN adds the FetchCount and StallCycles counters.
module instr_fetch_stage import fetch_pkg::*; #(
    parameter int          DEPTH    = DEFAULT_DEPTH,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                Clk,
    input  logic                Reset,
    instr_fetch_stage_if.master memBus,
    input  logic                Stall,
    input  logic                Redirect,
    input  logic [31:0]         RedirectPC,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]         FetchCount,
    output logic [31:0]         StallCycles,
`endif
    output logic [31:0]         InstrOut,
    output logic [31:0]         PCOut,
    output logic                InstrValid
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] CAP = (CW+1)'(DEPTH);
    logic [31:0] pc, respPc;
    logic [CW-1:0] outstanding, drop, count, nextDrop;
    logic [0:0] state;
    logic gnt, resp, push, pop, full, empty;
    fetchEntry_t head, newEntry;
    assign gnt = memBus.MemReq && memBus.MemGnt;
    assign resp = memBus.MemRespValid;
    // Buffered plus in-flight words never exceed DEPTH, so a response always has a slot.
    assign memBus.MemReq = !Reset && !Redirect && state == FETCH
                           && ({1'b0, count} + {1'b0, outstanding}) < CAP;
    assign memBus.MemAddr = pc;
    // Responses are in order, so the oldest in-flight word sits outstanding words behind the PC.
    assign respPc = pc - (32'(outstanding) << 2);
    assign newEntry = '{pc: respPc, instr: memBus.MemRespData};
    assign push = resp && state == FETCH;
    assign pop = !empty && !Stall;
    assign nextDrop = outstanding + CW'(gnt) - CW'(resp);
    assign InstrValid = !empty;
    assign InstrOut = empty ? NOP : head.instr;
    assign PCOut = empty ? 32'h0 : head.pc;
    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .Clk(Clk),
        .Reset(Reset),
        .push(push),
        .pop(pop),
        .flush(Redirect),
        .entry(newEntry),
        .full(full),
        .empty(empty),
        .count(count),
        .head(head)
    );
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc <= RESET_PC;
            outstanding <= '0;
            drop <= '0;
            state <= FETCH;
        end else if (Redirect) begin
            pc <= wordAlign(RedirectPC);
            outstanding <= '0;
            if (state == FETCH) begin
                drop <= nextDrop;
                state <= nextDrop != '0 ? DRAIN : FETCH;
            end else if (resp) begin
                drop <= drop - CW'(1);
                state <= drop == CW'(1) ? FETCH : DRAIN;
            end
        end else if (state == FETCH) begin
            if (gnt) pc <= pc + 32'd4;
            outstanding <= nextDrop;
        end else if (resp) begin
            drop <= drop - CW'(1);
            if (drop == CW'(1)) state <= FETCH;
        end
    end
    always_ff @(posedge Clk) begin
        if (!Reset && push && !Redirect) assert (!full || pop);
    end
`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge Clk) begin
        if (Reset) begin
            FetchCount <= '0;
            StallCycles <= '0;
        end else begin
            if (pop) FetchCount <= FetchCount + 32'd1;
            if (!empty && Stall) StallCycles <= StallCycles + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_instr_fetch_stage.sv
// tb_instr_fetch_stage: random memory/decode stimulus; scoreboard of the expected sequential instruction stream.
module tb_instr_fetch_stage;
    import fetch_pkg::*;
    localparam int DEPTH = 4;
    localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
    typedef struct { logic [31:0] addr; int due; } memReq_t;

    logic Clk = 1'b0, Reset, Stall, Redirect, InstrValid;
    logic [31:0] RedirectPC, InstrOut, PCOut;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] FetchCount, StallCycles;
`endif
    instr_fetch_stage_if memBus();

    instr_fetch_stage #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
        .Clk(Clk),
        .Reset(Reset),
        .memBus(memBus),
        .Stall(Stall),
        .Redirect(Redirect),
        .RedirectPC(RedirectPC),
`ifdef FETCH_PERF_CNT_EN
        .FetchCount(FetchCount),
        .StallCycles(StallCycles),
`endif
        .InstrOut(InstrOut),
        .PCOut(PCOut),
        .InstrValid(InstrValid)
    );

    always #5 Clk = ~Clk;

    int checks = 0, errors = 0, cyc = 0;
    int gntPct, respPct, minLat, maxLat;
    memReq_t memQ[$];
    fetchEntry_t expQ[$];
    logic [31:0] modelPc;
    logic [31:0] fetchRef = 0, stallRef = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    function automatic logic [31:0] wordAt(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory side: grant per gntPct, answer the oldest request once its latency has elapsed.
    task automatic cycle();
        @(posedge Clk);
        #1;
        memBus.MemGnt = ($urandom_range(99) < gntPct);
        if (memQ.size() > 0 && memQ[0].due <= cyc && $urandom_range(99) < respPct) begin
            memBus.MemRespValid = 1'b1;
            memBus.MemRespData = wordAt(memQ[0].addr);
            void'(memQ.pop_front());
        end else begin
            memBus.MemRespValid = 1'b0;
            memBus.MemRespData = $urandom;
        end
    endtask

    // Reference: the correct path is a sequential word stream from the last reset/redirect target.
    always @(negedge Clk) begin
        #1;
        if (Reset) begin
            expQ.delete();
            memQ.delete();
            modelPc = RST_PC;
        end else begin
            if (memBus.MemReq && memBus.MemGnt) begin
                chk("mem_addr", memBus.MemAddr, modelPc);
                memQ.push_back('{memBus.MemAddr, cyc + $urandom_range(maxLat, minLat)});
                expQ.push_back('{pc: modelPc, instr: wordAt(modelPc)});
                modelPc = modelPc + 32'd4;
                chk("credit_limit", 32'(expQ.size() <= DEPTH), 32'd1);
            end
            if (Redirect) begin
                expQ.delete();
                modelPc = RedirectPC & ~32'h3;
            end
        end
    end

    always @(negedge Clk) begin
        if (Reset) begin
            fetchRef = 0;
            stallRef = 0;
        end else begin
`ifdef FETCH_PERF_CNT_EN
            chk("perf_fetch", FetchCount, fetchRef);
            chk("perf_stall", StallCycles, stallRef);
`endif
            if (InstrValid) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_instr: got pc %h instr %h, required no instruction", PCOut, InstrOut);
                end else begin
                    chk("out_pc", PCOut, expQ[0].pc);
                    chk("out_instr", InstrOut, expQ[0].instr);
                    if (!Stall) void'(expQ.pop_front());
                end
                if (Stall) stallRef++;
                else fetchRef++;
            end else begin
                chk("nop_when_idle", InstrOut, NOP);
            end
        end
    end

    initial begin
        bit found;
        Reset = 1'b1; Stall = 1'b0; Redirect = 1'b0; RedirectPC = '0;
        memBus.MemGnt = 1'b0; memBus.MemRespValid = 1'b0; memBus.MemRespData = '0;
        gntPct = 100; respPct = 100; minLat = 1; maxLat = 1;
        cycle(); cycle();
        @(negedge Clk);
        chk("reset_memreq", memBus.MemReq, 0);
        chk("reset_valid", InstrValid, 0);
        chk("reset_instr", InstrOut, 0);
        chk("reset_pcout", PCOut, 0);
        chk("reset_addr", memBus.MemAddr, RST_PC);

        cycle(); Reset = 1'b0;
        @(negedge Clk); chk("first_valid_c1", InstrValid, 0);
        cycle();
        @(negedge Clk); chk("first_valid_c2", InstrValid, 0);
        for (int i = 0; i < 10; i++) begin
            cycle();
            @(negedge Clk);
            chk("stream_valid", InstrValid, 1);
            if (i < 4) chk("wrap_pcout", PCOut, RST_PC + 32'(4 * i));
        end

        for (int i = 0; i < 6; i++) begin cycle(); Stall = 1'b1; end
        @(negedge Clk);
        chk("stall_memreq", memBus.MemReq, 0);
        chk("stall_valid", InstrValid, 1);
        cycle(); Stall = 1'b0;
        repeat (10) cycle();

        minLat = 3; maxLat = 3;
        repeat (5) cycle();
        cycle(); Redirect = 1'b1; RedirectPC = 32'h0000_0103;
        cycle(); Redirect = 1'b0;
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge Clk);
            if (InstrValid) begin
                found = 1;
                chk("redirect_first_pc", PCOut, 32'h0000_0100);
            end else cycle();
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL redirect_timeout: got no valid instruction, required PCOut 00000100 within 30 cycles");
        end

        minLat = 1; maxLat = 1;
        repeat (6) cycle();
        cycle(); Redirect = 1'b1; RedirectPC = 32'h0000_0200;
        cycle(); Redirect = 1'b0;
        repeat (15) cycle();

        gntPct = 70; respPct = 70; minLat = 1; maxLat = 4;
        for (int i = 0; i < 3000; i++) begin
            cycle();
            Stall = ($urandom_range(3) == 0);
            Redirect = ($urandom_range(39) == 0);
            RedirectPC = $urandom;
        end
        Redirect = 1'b0; Stall = 1'b0;

        gntPct = 100; respPct = 100; minLat = 1; maxLat = 1;
        repeat (4) cycle();
        for (int i = 0; i < 8; i++) begin cycle(); Stall = 1'b1; end
        @(negedge Clk);
        chk("full_before_reset", InstrValid, 1);
        cycle(); Reset = 1'b1;
        cycle(); Reset = 1'b0; Stall = 1'b0;
        @(negedge Clk);
        chk("post_reset_valid", InstrValid, 0);
        chk("post_reset_addr", memBus.MemAddr, RST_PC);
`ifdef FETCH_PERF_CNT_EN
        chk("post_reset_fetchcount", FetchCount, 0);
`endif
        repeat (20) cycle();
        @(negedge Clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
